serdes_var: RTL and testbench
=============================

# serdes_var

Variable-length, width-parametrised serialiser/deserialiser that owns its own N-slot word buffer. Each command runs serialise, deserialise, or both at once, for 0..N words. A command may start in the same cycle as its first word transfer. It sits between 64-bit-style streaming ports (e.g. SHAKE/matrix streams) and wide parallel datapaths, replacing fixed-length serdes instances that relied on an external buffer.

## Interface
Parameters:
- W, 64, word width in bits (≥1)
- N, 4, maximum words per command and buffer depth (≥1)
- CW, $clog2(N+1), width of the word-count field (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high; clears all state
- cmd_startDes  in  1  command requests deserialisation
- cmd_startSer  in  1  command requests serialisation (may be combined with cmd_startDes)
- cmd_numWords  in  CW  word count sampled at command accept; values >N clamp to N
- cmd_canReceive  out  1  idle, so a command can be accepted
- des  in  W  incoming word
- des_isReady  in  1  incoming word valid
- des_canReceive  out  1  block accepts des this cycle
- des_isLast  out  1  current des transfer is the command's last
- ser  out  W  outgoing word, always equal to buffer slot 0
- ser_isReady  out  1  ser valid this cycle
- ser_canReceive  in  1  downstream accepts ser
- ser_isLast  out  1  current ser transfer is the command's last
- par_load  in  1  parallel load request
- par_in  in  N*W  parallel load data; slot j = bits [j*W +: W]
- par_out  out  N*W  buffer contents, same slot packing

## Operation
- Accept: a command is accepted when cmd_canReceive=1 and (cmd_startSer|cmd_startDes)=1.
  - Latch isSer, isDes and k=min(cmd_numWords,N).
  - Mode and k take effect combinationally in the accept cycle.
- Active state: remaining ≠ 0. cmd_canReceive = (remaining==0).
- Transfer condition: xfer = active & (isDes ? des_isReady : 1) & (isSer ? ser_canReceive : 1).
- Handshake outputs:
  - des_canReceive = isDes & active & (isSer ? ser_canReceive : 1).
  - ser_isReady = isSer & active & (isDes ? des_isReady : 1).
- Buffer window is slots 0..k-1. On xfer:
  - slot j ← slot j+1 for j<k-1.
  - slot k-1 ← des when isDes; slot k-1 ← slot 0 when ser-only, so the buffer rotates and contents are preserved.
  - Slots ≥k are untouched.
- Result of a complete command:
  - After a des command of k words, word i sits in slot i.
  - A ser command emits slots 0..k-1 in order and leaves the buffer as before.
  - Combined mode emits the old contents while filling the new ones.
- remaining is decremented on each xfer.
- des_isLast = ser_isLast = xfer & (remaining==1).
- k=0: the command is accepted, no transfer occurs, and the block is idle again the next cycle.
- par_load is honoured only when idle and no command is accepted in the same cycle (the command wins). It loads all N slots from par_in on the next edge. par_load while busy is ignored.

## Timing
- Reset values: cmd_canReceive=1; des_canReceive=0; ser_isReady=0; des_isLast=0; ser_isLast=0; ser=0; par_out=0.
- Zero-latency start: the first word may transfer in the accept cycle. A k-word command with no stalls occupies exactly k cycles.
- A new command can be accepted in the cycle after the last transfer. There is no back-to-back accept in the last-transfer cycle.
- Stalls (des_isReady=0 or ser_canReceive=0) hold all state. There is no timeout.
- Asserting rst mid-command immediately clears the buffer, counter and mode. The partial command is discarded and outputs return to their reset values without waiting for clk.
- cmd inputs are ignored while busy, and cmd_numWords changes while busy have no effect.

## Configuration
- SERDES_VAR_PAR_EN
  - Defined: the parallel port operates as described.
  - Undefined: no logic is generated for it. par_load and par_in are ignored, and par_out is tied to 0. The buffer is then reachable only through ser/des.

## Test plan
- W=64, N=4. Des with k=4, words 0x11,0x22,0x33,0x44 with no stalls -> done in 4 cycles; par_out slots 0..3 = 0x11..0x44; des_isLast only on 0x44; cmd_canReceive=1 on cycle 5.
- After the previous test, ser with k=4 and ser_canReceive toggled every other cycle -> ser emits 0x11,0x22,0x33,0x44 over 8 cycles; buffer unchanged afterwards.
- Combined ser+des, k=2, des=0xA,0xB over buffer {1,2,3,4} -> ser emits 1,2; final slots {0xA,0xB,3,4}.
- k=0 -> accepted, no des_canReceive/ser_isReady pulse, cmd_canReceive high next cycle; k=7 with N=4 -> exactly 4 transfers.
- par_load together with cmd_startDes -> load ignored and command runs. par_load while idle with 0x..DEADBEEF -> par_out updates next cycle. With SERDES_VAR_PAR_EN undefined -> par_out stays 0.
- rst pulsed after 2 of 4 des words -> outputs return to reset values at once; par_out=0; a new k=1 command completes normally.

Source files
------------

// File: rtl/serdes_var.sv
// serdes_var: variable-length serialiser/deserialiser with an internal N-slot
// word buffer. One command moves 0..N words and can serialise, deserialise, or
// both at once. The first word may move in the same cycle the command is accepted.
// Optional parallel load/readback port: define SERDES_VAR_PAR_EN to enable it.
// When the macro is undefined, par_load/par_in are ignored and par_out is tied to 0.
module serdes_var #(
  parameter int W  = 64,
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_startDes,
  input  logic            cmd_startSer,
  input  logic [CW-1:0]   cmd_numWords,
  output logic            cmd_canReceive,
  input  logic [W-1:0]    des,
  input  logic            des_isReady,
  output logic            des_canReceive,
  output logic            des_isLast,
  output logic [W-1:0]    ser,
  output logic            ser_isReady,
  input  logic            ser_canReceive,
  output logic            ser_isLast,
  input  logic            par_load,
  input  logic [N*W-1:0]  par_in,
  output logic [N*W-1:0]  par_out
);

  // Buffer storage and command state
  logic [W-1:0]  r_buf [N];
  logic [CW-1:0] r_remaining;
  logic [CW-1:0] r_k;
  logic          r_is_ser;
  logic          r_is_des;

  // Effective (accept-cycle aware) command view
  logic          w_idle;
  logic          w_accept;
  logic [CW-1:0] w_k_req;
  logic [CW-1:0] w_k;
  logic [CW-1:0] w_rem;
  logic          w_is_ser;
  logic          w_is_des;
  logic          w_active;
  logic          w_xfer;
  logic          w_last;
  logic [31:0]   w_k32;

  // Buffer next-state helpers
  logic [W-1:0]  w_up      [N];
  logic [W-1:0]  w_buf_nxt [N];

  // Command decode: a fresh command takes effect combinationally in its accept cycle
  always_comb begin
    w_idle   = (r_remaining == {CW{1'b0}});
    // Reset masks the accept path so outputs fall to reset values immediately.
    w_accept = w_idle & (cmd_startSer | cmd_startDes) & ~rst;

    if (32'(cmd_numWords) > 32'(N)) begin
      w_k_req = CW'(N);
    end else begin
      w_k_req = cmd_numWords;
    end

    if (w_accept) begin
      w_is_ser = cmd_startSer;
      w_is_des = cmd_startDes;
      w_k      = w_k_req;
      w_rem    = w_k_req;
    end else begin
      w_is_ser = r_is_ser;
      w_is_des = r_is_des;
      w_k      = r_k;
      w_rem    = r_remaining;
    end

    w_k32    = 32'(w_k);
    w_active = (w_rem != {CW{1'b0}});
    w_xfer   = w_active
             & (w_is_des ? des_isReady    : 1'b1)
             & (w_is_ser ? ser_canReceive : 1'b1);
    w_last   = w_xfer & (w_rem == CW'(1));
  end

  // Window shift: slot j takes slot j+1 below k-1; slot k-1 takes des or wraps slot 0
  always_comb begin
    for (int j = 0; j < N; j++) begin
      w_up[j] = r_buf[j];
    end
    for (int j = 0; j < N - 1; j++) begin
      w_up[j] = r_buf[j + 1];
    end
    for (int j = 0; j < N; j++) begin
      if (w_xfer) begin
        if ((32'(j) + 32'd1) < w_k32) begin
          w_buf_nxt[j] = w_up[j];
        end else if ((32'(j) + 32'd1) == w_k32) begin
          w_buf_nxt[j] = w_is_des ? des : r_buf[0];
        end else begin
          w_buf_nxt[j] = r_buf[j];
        end
      end else begin
        w_buf_nxt[j] = r_buf[j];
      end
    end
  end

  // Command state: latch mode and clamped count on accept, count down on each transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remaining <= {CW{1'b0}};
      r_k         <= {CW{1'b0}};
      r_is_ser    <= 1'b0;
      r_is_des    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_is_ser <= cmd_startSer;
        r_is_des <= cmd_startDes;
        r_k      <= w_k_req;
      end
      if (w_xfer) begin
        r_remaining <= w_rem - CW'(1);
      end else begin
        r_remaining <= w_rem;
      end
    end
  end

`ifdef SERDES_VAR_PAR_EN
  logic w_par_take;

  // A parallel load only lands when idle and no command claims the same cycle
  assign w_par_take = par_load & w_idle & ~w_accept;

  // Buffer slots: parallel load when idle, otherwise the transfer window update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N; j++) begin
        r_buf[j] <= {W{1'b0}};
      end
    end else if (w_par_take) begin
      for (int j = 0; j < N; j++) begin
        r_buf[j] <= par_in[j*W +: W];
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        r_buf[j] <= w_buf_nxt[j];
      end
    end
  end

  // Parallel readback of every slot, slot j at bits [j*W +: W]
  always_comb begin
    par_out = {(N*W){1'b0}};
    for (int j = 0; j < N; j++) begin
      par_out[j*W +: W] = r_buf[j];
    end
  end
`else
  logic w_unused_par;

  // Parallel port is absent: inputs are only sunk, readback is constant zero
  assign w_unused_par = ^{par_load, par_in};
  assign par_out      = {(N*W){1'b0}};

  // Buffer slots: reachable only through the ser/des window update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N; j++) begin
        r_buf[j] <= {W{1'b0}};
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        r_buf[j] <= w_buf_nxt[j];
      end
    end
  end
`endif

  // Handshake and status outputs
  assign cmd_canReceive = w_idle;
  assign des_canReceive = w_is_des & w_active & (w_is_ser ? ser_canReceive : 1'b1);
  assign ser_isReady    = w_is_ser & w_active & (w_is_des ? des_isReady : 1'b1);
  assign des_isLast     = w_last;
  assign ser_isLast     = w_last;
  assign ser            = r_buf[0];

endmodule

// File: tb/tb_serdes_var.sv
// Randomised scoreboard bench for serdes_var (W=64, N=4). A command-level model
// predicts emitted words and the final buffer; a monitor compares transfers.
// Parallel-port checks follow SERDES_VAR_PAR_EN the same way the design does.
`timescale 1ns/1ps
module tb_serdes_var;
  localparam int W  = 64;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);
  localparam int PW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_startDes, cmd_startSer;
  logic [CW-1:0] cmd_numWords;
  logic          cmd_canReceive;
  logic [W-1:0]  des;
  logic          des_isReady, des_canReceive, des_isLast;
  logic [W-1:0]  ser;
  logic          ser_isReady, ser_canReceive, ser_isLast;
  logic          par_load;
  logic [PW-1:0] par_in, par_out;

  serdes_var #(.W(W), .N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_startDes(cmd_startDes), .cmd_startSer(cmd_startSer),
    .cmd_numWords(cmd_numWords), .cmd_canReceive(cmd_canReceive),
    .des(des), .des_isReady(des_isReady), .des_canReceive(des_canReceive),
    .des_isLast(des_isLast),
    .ser(ser), .ser_isReady(ser_isReady), .ser_canReceive(ser_canReceive),
    .ser_isLast(ser_isLast),
    .par_load(par_load), .par_in(par_in), .par_out(par_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: buffer contents as the spec describes them after each whole command
  logic [W-1:0] m_buf   [N];
  logic [W-1:0] fixed_w [N];
  logic [W-1:0] ser_wq [$];
  bit           ser_lq [$];
  bit           des_lq [$];

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_par();
    logic [PW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'({$urandom, $urandom});
    return r;
  endfunction

  task automatic check_par(input string name);
    logic [PW-1:0] e;
    e = {PW{1'b0}};
`ifdef SERDES_VAR_PAR_EN
    for (int i = 0; i < N; i++) e[i*W +: W] = m_buf[i];
`endif
    check(name, par_out, e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_canReceive"}, PW'(cmd_canReceive), PW'(1));
    check({tag, "_des_canReceive"}, PW'(des_canReceive), PW'(0));
    check({tag, "_ser_isReady"},    PW'(ser_isReady),    PW'(0));
    check({tag, "_des_isLast"},     PW'(des_isLast),     PW'(0));
    check({tag, "_ser_isLast"},     PW'(ser_isLast),     PW'(0));
    check({tag, "_ser"},            PW'(ser),            PW'(0));
    check({tag, "_par_out"},        par_out,             PW'(0));
  endtask

  // Monitor: pop expectations whenever the DUT completes a handshake
  always @(negedge clk) begin : monitor
    bit s_x, d_x;
    if (!rst) begin
      s_x = ser_isReady && ser_canReceive;
      d_x = des_canReceive && des_isReady;
      check("last_flags_equal", PW'(ser_isLast), PW'(des_isLast));
      if (s_x) begin
        if (ser_wq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL ser_unexpected: got word %0h with no word expected", ser);
        end else begin
          check("ser_word",   PW'(ser),        PW'(ser_wq.pop_front()));
          check("ser_isLast", PW'(ser_isLast), PW'(ser_lq.pop_front()));
        end
      end
      if (d_x) begin
        if (des_lq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL des_unexpected: got des transfer with no transfer expected");
        end else begin
          check("des_isLast", PW'(des_isLast), PW'(des_lq.pop_front()));
        end
      end
      if (!s_x && !d_x) check("last_when_idle", PW'(des_isLast), PW'(0));
    end
  end

  // One command: s/d mode, num words, stall modes (0 none, 1 toggle, 2 random)
  task automatic run_cmd(input bit s, input bit d, input int num, input int ser_st,
                         input int des_st, input bit use_fixed, input bit par_with,
                         input int abort_at, input int exp_cycles);
    int k, idx, cyc;
    bit xf;
    logic [W-1:0] w [N];
    k = (num > N) ? N : num;
    for (int i = 0; i < N; i++) w[i] = use_fixed ? fixed_w[i] : W'({$urandom, $urandom});
    for (int i = 0; i < k; i++) begin
      if (s) begin ser_wq.push_back(m_buf[i]); ser_lq.push_back(i == k - 1); end
      if (d) des_lq.push_back(i == k - 1);
    end
    cyc = 0; idx = 0;
    @(posedge clk); #1;
    cmd_startSer = s; cmd_startDes = d; cmd_numWords = CW'(num);
    par_load = par_with; par_in = rand_par();
    des = w[0];
    des_isReady    = (des_st == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
    ser_canReceive = (ser_st == 0) ? 1'b1 : (ser_st == 1) ? 1'b0 : 1'(($urandom_range(0, 1)));
    forever begin
      @(negedge clk);
      if (k == 0) begin
        check("k0_des_canReceive", PW'(des_canReceive), PW'(0));
        check("k0_ser_isReady",    PW'(ser_isReady),    PW'(0));
      end
      xf = d ? (des_canReceive && des_isReady) : (ser_isReady && ser_canReceive);
      cyc++;
      @(posedge clk); #1;
      if (xf) idx++;
      cmd_startSer = 1'b0; cmd_startDes = 1'b0; par_load = 1'b0;
      if (idx >= k) break;
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b1; #1;
        check_reset_outputs("mid_reset");
        ser_wq.delete(); ser_lq.delete(); des_lq.delete();
        for (int i = 0; i < N; i++) m_buf[i] = {W{1'b0}};
        des_isReady = 1'b0; ser_canReceive = 1'b0; cmd_numWords = {CW{1'b0}};
        @(negedge clk); #2;
        rst = 1'b0;
        return;
      end
      if (cyc >= 200) begin
        n_tests++; n_fail++;
        $display("FAIL cmd_timeout: got %0d of %0d transfers after %0d cycles", idx, k, cyc);
        ser_wq.delete(); ser_lq.delete(); des_lq.delete();
        break;
      end
      // Busy: command and parallel inputs must be ignored
      cmd_startSer = 1'(($urandom_range(0, 1)));
      cmd_startDes = 1'(($urandom_range(0, 1)));
      cmd_numWords = CW'($urandom_range(0, 7));
      par_load     = 1'(($urandom_range(0, 1)));
      par_in       = rand_par();
      des          = w[idx];
      des_isReady    = (des_st == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
      ser_canReceive = (ser_st == 0) ? 1'b1 : (ser_st == 1) ? 1'((cyc % 2)) : 1'(($urandom_range(0, 1)));
    end
    cmd_numWords = {CW{1'b0}}; des_isReady = 1'b0; ser_canReceive = 1'b0;
    check("cmd_canReceive_after", PW'(cmd_canReceive), PW'(1));
    if (exp_cycles >= 0) check("cmd_cycles", PW'(cyc), PW'(exp_cycles));
    if (d) for (int i = 0; i < k; i++) m_buf[i] = w[i];
    check_par("par_out_after_cmd");
  endtask

  task automatic par_load_idle(input logic [PW-1:0] v);
    @(posedge clk); #1;
    par_load = 1'b1; par_in = v;
    @(posedge clk); #1;
    par_load = 1'b0;
`ifdef SERDES_VAR_PAR_EN
    for (int i = 0; i < N; i++) m_buf[i] = v[i*W +: W];
`endif
    check_par("par_load_idle");
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int mode, num;
    rst = 1'b1;
    cmd_startDes = 1'b0; cmd_startSer = 1'b0; cmd_numWords = {CW{1'b0}};
    des = {W{1'b0}}; des_isReady = 1'b0; ser_canReceive = 1'b0;
    par_load = 1'b0; par_in = {PW{1'b0}};
    for (int i = 0; i < N; i++) m_buf[i] = {W{1'b0}};
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0;

    // Directed: des 0x11..0x44, then ser with toggling backpressure
    fixed_w[0] = 64'h11; fixed_w[1] = 64'h22; fixed_w[2] = 64'h33; fixed_w[3] = 64'h44;
    run_cmd(1'b0, 1'b1, 4, 0, 0, 1'b1, 1'b0, -1, 4);
    run_cmd(1'b1, 1'b0, 4, 1, 0, 1'b0, 1'b0, -1, 8);
    run_cmd(1'b1, 1'b0, 4, 0, 0, 1'b0, 1'b0, -1, 4);

    // Combined k=2 over {1,2,3,4}, then read the buffer back through ser
    fixed_w[0] = 64'h1; fixed_w[1] = 64'h2; fixed_w[2] = 64'h3; fixed_w[3] = 64'h4;
    run_cmd(1'b0, 1'b1, 4, 0, 0, 1'b1, 1'b0, -1, 4);
    fixed_w[0] = 64'hA; fixed_w[1] = 64'hB;
    run_cmd(1'b1, 1'b1, 2, 0, 0, 1'b1, 1'b0, -1, 2);
    run_cmd(1'b1, 1'b0, 4, 0, 0, 1'b0, 1'b0, -1, 4);

    // k=0 and clamping of k=7
    run_cmd(1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0, -1, 1);
    run_cmd(1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, -1, 1);
    run_cmd(1'b1, 1'b1, 7, 0, 0, 1'b0, 1'b0, -1, 4);
    run_cmd(1'b1, 1'b0, 4, 0, 0, 1'b0, 1'b0, -1, 4);

    // Parallel load colliding with a command, then an idle load
    run_cmd(1'b0, 1'b1, 3, 0, 0, 1'b0, 1'b1, -1, 3);
    par_load_idle({64'h4444_4444_DEAD_BEEF, 64'h3333_3333_DEAD_BEEF,
                   64'h2222_2222_DEAD_BEEF, 64'h1111_1111_DEAD_BEEF});
    run_cmd(1'b1, 1'b0, 4, 0, 0, 1'b0, 1'b0, -1, 4);

    // Reset after 2 of 4 des words, then a normal k=1 command
    run_cmd(1'b0, 1'b1, 4, 0, 0, 1'b0, 1'b0, 2, -1);
    run_cmd(1'b0, 1'b1, 1, 0, 0, 1'b0, 1'b0, -1, 1);
    run_cmd(1'b1, 1'b0, 4, 0, 0, 1'b0, 1'b0, -1, 4);

    // Randomised commands with random stalls and idle parallel loads
    for (int t = 0; t < 60; t++) begin
      mode = $urandom_range(1, 3);
      num  = $urandom_range(0, 7);
      run_cmd((mode & 1) != 0, (mode & 2) != 0, num, 2 * $urandom_range(0, 1),
              2 * $urandom_range(0, 1), 1'b0, 1'($urandom_range(0, 1)), -1, -1);
      if ($urandom_range(0, 4) == 0) par_load_idle(rand_par());
    end
    run_cmd(1'b1, 1'b0, 4, 2, 0, 1'b0, 1'b0, -1, -1);

    @(posedge clk); #1;
    check("ser_queue_drained", PW'(ser_wq.size()), PW'(0));
    check("des_queue_drained", PW'(des_lq.size()), PW'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
